// File: rtl/pipeline_nbit_addsub.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_nbit_addsub
// Brief   : Pipelined ripple-segment adder/subtractor with valid/ready flow.
// Rev     : 1.0  initial release
// ============================================================================
module pipeline_nbit_addsub #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int c_SEG = WIDTH / STAGES;

    logic                         w_advance;
    logic [STAGES-1:0]            valid_q;
    logic [STAGES-1:0]            carry_q;
    logic [STAGES-1:0][WIDTH-1:0] a_q;
    logic [STAGES-1:0][WIDTH-1:0] b_q;
    logic [STAGES-1:0][WIDTH-1:0] sum_q;
    logic                         ovf_q;

    // Stage k reads the registers of stage k-1; stage 0 reads the prepared inputs.
    logic [STAGES-1:0]            w_src_valid;
    logic [STAGES-1:0]            w_src_carry;
    logic [STAGES-1:0][WIDTH-1:0] w_src_a;
    logic [STAGES-1:0][WIDTH-1:0] w_src_b;
    logic [STAGES-1:0][WIDTH-1:0] w_src_sum;
    logic [STAGES-1:0][WIDTH-1:0] sum_d;
    logic [STAGES-1:0]            carry_d;
    logic                         ovf_d;
    logic [c_SEG:0]               w_slice;
    logic                         w_unused;

    assign w_advance = ~valid_q[STAGES-1] | out_ready;
    assign in_ready  = w_advance;
    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign ovf       = ovf_q;

    // The last stage's operand copies have no consumer.
    assign w_unused  = ^{a_q[STAGES-1], b_q[STAGES-1]};

    always_comb begin
        w_src_valid    = '0;
        w_src_carry    = '0;
        w_src_a        = '0;
        w_src_b        = '0;
        w_src_sum      = '0;
        sum_d          = '0;
        carry_d        = '0;
        w_slice        = '0;
        w_src_valid[0] = in_valid;
        w_src_a[0]     = a;
        w_src_b[0]     = sub ? ~b : b;
        w_src_carry[0] = sub ? ~cin : cin;
        for (int k = 1; k < STAGES; k++) begin
            w_src_valid[k] = valid_q[k-1];
            w_src_carry[k] = carry_q[k-1];
            w_src_a[k]     = a_q[k-1];
            w_src_b[k]     = b_q[k-1];
            w_src_sum[k]   = sum_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_slice = {1'b0, w_src_a[k][k*c_SEG +: c_SEG]}
                    + {1'b0, w_src_b[k][k*c_SEG +: c_SEG]}
                    + {{c_SEG{1'b0}}, w_src_carry[k]};
            sum_d[k]                  = w_src_sum[k];
            sum_d[k][k*c_SEG +: c_SEG] = w_slice[c_SEG-1:0];
            carry_d[k]                = w_slice[c_SEG];
        end
        // a^b^s at the MSB recovers the carry into the MSB.
        ovf_d = w_src_a[STAGES-1][WIDTH-1] ^ w_src_b[STAGES-1][WIDTH-1]
              ^ sum_d[STAGES-1][WIDTH-1] ^ carry_d[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (w_advance) begin
            valid_q <= w_src_valid;
            for (int k = 0; k < STAGES; k++) begin
                if (w_src_valid[k]) begin
                    a_q[k]     <= w_src_a[k];
                    b_q[k]     <= w_src_b[k];
                    sum_q[k]   <= sum_d[k];
                    carry_q[k] <= carry_d[k];
                end
            end
            if (w_src_valid[STAGES-1]) begin
                ovf_q <= ovf_d;
            end
        end
    end
endmodule
`default_nettype wire
